aes_round_key_bank: RTL



---
 rtl/aes_round_key_bank.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/aes_round_key_bank.sv
// Multi-bank AES round-key store. Round keys arrive in BUS_W-wide beats and
// are written into one of NUM_BANKS banks. The active bank (key_idx) feeds the
// round core one registered 128-bit key per cycle. The active bank can only
// move to a bank that holds a complete key set, and only while the core is idle.
//
// Handshake: en_wr is a one-cycle write beat with no backpressure; every beat
// with en_wr=1 is consumed on that rising edge. switch_key is a one-cycle
// request that is answered either by a commit (immediately or deferred via
// switch_pending) or by a one-cycle switch_err_irq_pulse on the next cycle.
module aes_round_key_bank #(
  parameter int BUS_W      = 64,
  parameter int NUM_BANKS  = 2,
  parameter int NUM_ROUNDS = 11,
  localparam int BW = ($clog2(NUM_BANKS) > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 kill,
  input  logic                 en_wr,
  input  logic [BUS_W-1:0]     key_round_wr,
  input  logic [BW-1:0]        wr_bank,
  input  logic                 switch_key,
  input  logic [BW-1:0]        switch_idx,
  input  logic                 core_idle,
  input  logic [3:0]           rd_round,
  output logic [127:0]         rd_key,
  output logic [BW-1:0]        key_idx,
  output logic [NUM_BANKS-1:0] bank_valid,
  output logic                 wr_busy,
  output logic                 switch_pending,
  output logic                 wr_err_irq_pulse,
  output logic                 switch_err_irq_pulse
);

  localparam int BPR   = 128 / BUS_W;
  localparam int TOTAL = NUM_ROUNDS * BPR;
  localparam int CW    = $clog2(TOTAL);

  localparam logic [CW-1:0] LAST_BEAT = CW'(TOTAL - 1);
  localparam logic [3:0]    NR4       = 4'(NUM_ROUNDS);
  localparam logic [BW:0]   NB        = (BW+1)'(NUM_BANKS);

  localparam logic [0:0] SW_IDLE = 1'b0;
  localparam logic [0:0] SW_PEND = 1'b1;

  // Key storage, one BUS_W word per beat; a round key is BPR consecutive words.
  logic [BUS_W-1:0] mem [NUM_BANKS][TOTAL];

  logic [CW-1:0]  beat_cnt;
  logic [BW-1:0]  wr_tgt;
  logic           wr_discard;
  logic [0:0]     sw_state;
  logic [BW-1:0]  pend_idx;

  logic           first_beat;
  logic           first_bad;
  logic           wr_live;
  logic           mem_we;
  logic [BW-1:0]  mem_bank;
  logic           sw_ok;
  logic [127:0]   rd_next;

  // Write-set acceptance and switch legality, all from the pre-edge state.
  always_comb begin
    first_beat = en_wr && !wr_busy;
    first_bad  = (wr_bank == key_idx) ||
                 ((sw_state == SW_PEND) && (wr_bank == pend_idx)) ||
                 ({1'b0, wr_bank} >= NB);
    wr_live    = wr_busy && !wr_discard;
    mem_we     = !kill && en_wr && ((first_beat && !first_bad) || (!first_beat && wr_live));
    mem_bank   = first_beat ? wr_bank : wr_tgt;
    sw_ok      = ({1'b0, switch_idx} < NB) && bank_valid[switch_idx] &&
                 !(wr_live && (wr_tgt == switch_idx));
  end

  // Assemble the requested round key of the active bank (zero when not servable).
  always_comb begin
    rd_next = '0;
    if (bank_valid[key_idx] && (rd_round < NR4)) begin
      for (int i = 0; i < BPR; i++) begin
        rd_next[i*BUS_W +: BUS_W] = mem[key_idx][CW'(int'(rd_round) * BPR + i)];
      end
    end
  end

  // Storage write port; contents survive kill.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_bank][beat_cnt] <= key_round_wr;
    end
  end

  // Control: write-set tracking, switch FSM, read register and irq pulses.
  always_ff @(posedge clk) begin
    if (kill) begin
      rd_key               <= '0;
      key_idx              <= '0;
      bank_valid           <= '0;
      wr_busy              <= 1'b0;
      wr_discard           <= 1'b0;
      wr_tgt               <= '0;
      beat_cnt             <= '0;
      sw_state             <= SW_IDLE;
      pend_idx             <= '0;
      wr_err_irq_pulse     <= 1'b0;
      switch_err_irq_pulse <= 1'b0;
    end else begin
      rd_key               <= rd_next;
      wr_err_irq_pulse     <= first_beat && first_bad;
      switch_err_irq_pulse <= 1'b0;

      if (en_wr) begin
        if (first_beat) begin
          wr_busy    <= 1'b1;
          wr_discard <= first_bad;
          wr_tgt     <= wr_bank;
          beat_cnt   <= CW'(1);
          if (!first_bad) begin
            bank_valid[wr_bank] <= 1'b0;
          end
        end else if (beat_cnt == LAST_BEAT) begin
          wr_busy    <= 1'b0;
          wr_discard <= 1'b0;
          beat_cnt   <= '0;
          if (!wr_discard) begin
            bank_valid[wr_tgt] <= 1'b1;
          end
        end else begin
          beat_cnt <= beat_cnt + CW'(1);
        end
      end

      if (sw_state == SW_IDLE) begin
        if (switch_key) begin
          if (!sw_ok) begin
            switch_err_irq_pulse <= 1'b1;
          end else if (switch_idx != key_idx) begin
            if (core_idle) begin
              key_idx <= switch_idx;
            end else begin
              pend_idx <= switch_idx;
              sw_state <= SW_PEND;
            end
          end
        end
      end else begin
        if (switch_key) begin
          switch_err_irq_pulse <= 1'b1;
        end
        if (core_idle) begin
          key_idx  <= pend_idx;
          sw_state <= SW_IDLE;
        end
      end
    end
  end

  assign switch_pending = (sw_state == SW_PEND);

endmodule
